// File: rtl/mem_ctrl.sv
// Memory-bus controller and round-robin arbiter for the byte-wide RAM/IO port.
// It serialises IF word fetches and LSB loads/stores into byte accesses.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_len,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state_reg;
    logic              owner_reg;        // 1 = LSB owns the bus
    logic              last_reg;         // 1 = LSB was granted last
    logic [ADDR_W-1:0] base_reg;
    logic [2:0]        n_reg;
    logic [2:0]        iss_reg;
    logic [2:0]        cap_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rbuf_reg;
    logic              resume_reg;
    logic              if_done_reg;
    logic              lsb_done_reg;
    logic              done_store_reg;
    logic [31:0]       if_data_reg;
    logic [31:0]       lsb_rdata_reg;

    logic [2:0]        iss_eff;
    logic              rd_issue;
    logic              rd_capture;
    logic              wr_active;
    logic              io_stall;
    logic [ADDR_W-1:0] cur_addr;
    logic              if_ok;
    logic              lsb_ok;
    logic              pick_lsb;
    logic [7:0]        wbyte [4];
    logic [31:0]       rbuf_next;

    // After a pause the byte in flight is stale, so issuing restarts at cap.
    assign iss_eff    = (state_reg == RD && resume_reg) ? cap_reg : iss_reg;
    assign rd_issue   = (state_reg == RD) && rdy_in && !clear && (iss_eff < n_reg);
    assign rd_capture = (state_reg == RD) && rdy_in && !clear && !resume_reg && (cap_reg < iss_reg);
    assign wr_active  = (state_reg == WR) && rdy_in;
    assign cur_addr   = base_reg + ADDR_W'(iss_eff);
    assign io_stall   = wr_active && (cur_addr[17:16] == 2'b11) && io_buffer_full;

    // A requester whose done pulse is showing this cycle is not re-granted.
    assign if_ok    = if_req && !clear && !if_done_reg;
    assign lsb_ok   = lsb_req && !lsb_done_reg;
    assign pick_lsb = lsb_ok && (!if_ok || !last_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdata_reg[8*gi +: 8];
            assign rbuf_next[8*gi +: 8] = (rd_capture && cap_reg[1:0] == 2'(gi))
                                          ? mem_din : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    assign mem_a     = (rd_issue || wr_active) ? cur_addr : '0;
    assign mem_dout  = wr_active ? wbyte[iss_reg[1:0]] : 8'h00;
    assign mem_wr    = wr_active && !io_stall;
    assign if_done   = if_done_reg && rdy_in && !clear;
    assign lsb_done  = lsb_done_reg && rdy_in && (done_store_reg || !clear);
    assign if_data   = if_data_reg;
    assign lsb_rdata = lsb_rdata_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_reg       <= 1'b0;
            base_reg       <= '0;
            n_reg          <= 3'd0;
            iss_reg        <= 3'd0;
            cap_reg        <= 3'd0;
            wdata_reg      <= 32'h0;
            rbuf_reg       <= 32'h0;
            resume_reg     <= 1'b0;
            if_done_reg    <= 1'b0;
            lsb_done_reg   <= 1'b0;
            done_store_reg <= 1'b0;
            if_data_reg    <= 32'h0;
            lsb_rdata_reg  <= 32'h0;
        end else begin
            resume_reg <= !rdy_in;
            // A pending pulse survives a pause but dies if a flush cancels it.
            if (rdy_in || (clear && !done_store_reg)) begin
                if_done_reg  <= 1'b0;
                lsb_done_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (rdy_in && (pick_lsb || if_ok)) begin
                        iss_reg  <= 3'd0;
                        cap_reg  <= 3'd0;
                        rbuf_reg <= 32'h0;
                        if (pick_lsb) begin
                            state_reg <= lsb_wr ? WR : RD;
                            owner_reg <= 1'b1;
                            last_reg  <= 1'b1;
                            base_reg  <= lsb_addr;
                            n_reg     <= {1'b0, lsb_len} + 3'd1;
                            wdata_reg <= lsb_wdata;
                        end else begin
                            state_reg <= RD;
                            owner_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            base_reg  <= if_addr;
                            n_reg     <= 3'd4;
                        end
                    end
                end
                RD: begin
                    if (clear) begin
                        state_reg <= IDLE;
                    end else if (rdy_in) begin
                        iss_reg  <= rd_issue ? iss_eff + 3'd1 : iss_eff;
                        rbuf_reg <= rbuf_next;
                        if (rd_capture) begin
                            cap_reg <= cap_reg + 3'd1;
                            if (cap_reg + 3'd1 == n_reg) begin
                                state_reg      <= IDLE;
                                done_store_reg <= 1'b0;
                                if (owner_reg) begin
                                    lsb_done_reg  <= 1'b1;
                                    lsb_rdata_reg <= rbuf_next;
                                end else begin
                                    if_done_reg <= 1'b1;
                                    if_data_reg <= rbuf_next;
                                end
                            end
                        end
                    end
                end
                WR: begin
                    // Stores are committed: a flush does not interrupt them.
                    if (wr_active && !io_stall) begin
                        iss_reg <= iss_reg + 3'd1;
                        if (iss_reg + 3'd1 == n_reg) begin
                            state_reg      <= IDLE;
                            lsb_done_reg   <= 1'b1;
                            done_store_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// transactions compared against a byte-addressed golden memory model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, if_req, lsb_req, lsb_wr, io_buffer_full;
    logic [31:0] if_addr, lsb_addr, lsb_wdata, if_data, lsb_rdata, mem_a;
    logic [1:0]  lsb_len;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic        if_done, lsb_done, mem_wr;

    int n_checks = 0;
    int n_errors = 0;
    int both_done = 0;

    logic [7:0]  ram  [logic [31:0]];
    logic [7:0]  gold [logic [31:0]];
    logic [31:0] alog [40];
    logic        wlog [40];
    logic [7:0]  dlog [40];

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    // Expected load result: n bytes little-endian from the golden memory, zero-extended.
    function automatic logic [31:0] gold_word(input logic [31:0] a, input int n);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = gold_rd(a + 32'(i));
        return w;
    endfunction

    task automatic gold_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) gold[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]  = b;
        gold[a] = b;
    endtask

    // RAM/IO device: one-cycle read latency, writes on the clock edge.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    always @(negedge clk_in) if (if_done && lsb_done) both_done++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One request from one requester; cycle 0 is the grant cycle. Called at posedge+1.
    task automatic do_req(input bit is_if, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int pause_c, input int clr_c, input int full_lo, input int full_hi,
                          output int done_c, output logic [31:0] data, output int nwr);
        done_c = -1;
        data   = 32'h0;
        nwr    = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) begin
                if (is_if) begin
                    if_req = 1'b1; if_addr = addr;
                end else begin
                    lsb_req = 1'b1; lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata;
                end
            end
            rdy_in = (c != pause_c);
            clear  = (c == clr_c);
            io_buffer_full = (c >= full_lo && c <= full_hi);
            if (clr_c >= 0 && c > clr_c && !wr) begin
                if_req = 1'b0; lsb_req = 1'b0;
            end
            @(negedge clk_in);
            alog[c] = mem_a;
            wlog[c] = mem_wr;
            dlog[c] = mem_dout;
            if (mem_wr) nwr++;
            if (c > 0 && (is_if ? if_done : lsb_done)) begin
                done_c = c;
                data   = is_if ? if_data : lsb_rdata;
            end
            @(posedge clk_in); #1;
            if (done_c >= 0) break;
        end
        if_req = 1'b0; lsb_req = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        $display("txn %s wr=%0d len=%0d addr=0x%08h done_cycle=%0d data=0x%08h writes=%0d",
                 is_if ? "IF " : "LSB", wr, len, addr, done_c, data, nwr);
    endtask

    // IF fetch and LSB byte load raised together in cycle 0.
    task automatic do_pair(input logic [31:0] ia, input logic [31:0] la,
                           output int ic, output int lc, output logic [31:0] id, output logic [31:0] ld);
        ic = -1; lc = -1; id = 32'h0; ld = 32'h0;
        if_req = 1'b1; if_addr = ia;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = la;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            if (c > 0 && if_done && ic < 0) begin ic = c; id = if_data; end
            if (c > 0 && lsb_done && lc < 0) begin lc = c; ld = lsb_rdata; end
            @(posedge clk_in); #1;
            if (ic >= 0) if_req = 1'b0;
            if (lc >= 0) lsb_req = 1'b0;
            if (ic >= 0 && lc >= 0) break;
        end
        if_req = 1'b0; lsb_req = 1'b0;
        $display("txn pair if_done_cycle=%0d lsb_done_cycle=%0d if_data=0x%08h lsb_rdata=0x%08h",
                 ic, lc, id, ld);
    endtask

    initial begin
        int dc, nw, ic, lc, n, pc, flo, fhi, exp_c;
        logic [31:0] d, id, ld, a;
        logic [1:0] len;
        bit is_if, wr;

        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; lsb_req = 1'b0; lsb_wr = 1'b0;
        lsb_len = 2'd0; lsb_addr = 32'h0; lsb_wdata = 32'h0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'hA0); preload(32'h103, 8'h00);
        preload(32'h2000, 8'h8F);
        for (int i = 0; i < 4; i++) preload(32'h40 + 32'(i), 8'($urandom));

        repeat (2) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        check_eq("rst_mem_a", mem_a, 32'h0);
        check_eq("rst_ctl", {21'h0, mem_wr, if_done, lsb_done, mem_dout}, 32'h0);
        check_eq("rst_if_data", if_data, 32'h0);
        check_eq("rst_lsb_rdata", lsb_rdata, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // IF-only word fetch
        do_req(1, 0, 2'd3, 32'h100, 32'h0, -1, -1, -1, -1, dc, d, nw);
        check_eq("if_done_cycle", dc, 6);
        check_eq("if_data", d, 32'h00A00513);
        for (int i = 1; i <= 4; i++) check_eq("if_addr_seq", alog[i], 32'h100 + 32'(i - 1));

        // Tie from reset arbitration state: LSB first, IF back-to-back
        do_pair(32'h100, 32'h2000, ic, lc, id, ld);
        check_eq("tie_lsb_cycle", lc, 3);
        check_eq("tie_lsb_data", ld, 32'h0000008F);
        check_eq("tie_if_cycle", ic, 9);
        check_eq("tie_if_data", id, 32'h00A00513);

        // UART store under back-pressure
        do_req(0, 1, 2'd0, 32'h30000, 32'h41, -1, -1, 1, 3, dc, d, nw);
        check_eq("uart_stall_wr", {29'h0, wlog[1], wlog[2], wlog[3]}, 32'h0);
        check_eq("uart_wr", {31'h0, wlog[4]}, 32'h1);
        check_eq("uart_dout", dlog[4], 8'h41);
        check_eq("uart_done_cycle", dc, 5);
        check_eq("uart_nwr", nw, 1);
        gold_store(32'h30000, 1, 32'h41);

        // Pause in cycle 3 of a word fetch
        do_req(1, 0, 2'd3, 32'h40, 32'h0, 3, -1, -1, -1, dc, d, nw);
        check_eq("pause_done_cycle", dc, 8);
        check_eq("pause_data", d, gold_word(32'h40, 4));
        check_eq("pause_reissue", alog[4], 32'h41);

        // Flush aborts a fetch; a store survives it
        do_req(1, 0, 2'd3, 32'h100, 32'h0, -1, 2, -1, -1, dc, d, nw);
        check_eq("clr_if_no_done", dc, -1);
        check_eq("clr_if_bus_idle", alog[3], 32'h0);
        do_req(0, 1, 2'd3, 32'h500, 32'hCAFEF00D, -1, 2, -1, -1, dc, d, nw);
        check_eq("clr_st_done_cycle", dc, 5);
        check_eq("clr_st_nwr", nw, 4);
        gold_store(32'h500, 4, 32'hCAFEF00D);
        do_req(0, 1, 2'd0, 32'h600, 32'h5A, -1, 2, -1, -1, dc, d, nw);
        check_eq("clr_st_done_kept", dc, 2);
        gold_store(32'h600, 1, 32'h5A);
        do_req(0, 0, 2'd0, 32'h600, 32'h0, -1, 3, -1, -1, dc, d, nw);
        check_eq("clr_ld_done_dropped", dc, -1);
        do_req(0, 0, 2'd3, 32'h500, 32'h0, -1, -1, -1, -1, dc, d, nw);
        check_eq("st_readback", d, 32'hCAFEF00D);

        // Unaligned half store across a 64 KiB boundary
        do_req(0, 1, 2'd1, 32'h1FFFF, 32'h0000BEEF, -1, -1, -1, -1, dc, d, nw);
        check_eq("half_done_cycle", dc, 3);
        check_eq("half_a0", alog[1], 32'h1FFFF);
        check_eq("half_d0", dlog[1], 8'hEF);
        check_eq("half_a1", alog[2], 32'h20000);
        check_eq("half_d1", dlog[2], 8'hBE);
        gold_store(32'h1FFFF, 2, 32'h0000BEEF);

        // Reset in cycle 1 of a fetch
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; if_req = 1'b0;
        @(negedge clk_in);
        check_eq("mid_rst_mem_a", mem_a, 32'h0);
        check_eq("mid_rst_ctl", {21'h0, mem_wr, if_done, lsb_done, mem_dout}, 32'h0);
        check_eq("mid_rst_if_data", if_data, 32'h0);
        check_eq("mid_rst_lsb_rdata", lsb_rdata, 32'h0);
        @(posedge clk_in); #1;

        // Randomized transactions against the golden memory
        for (int t = 0; t < 40; t++) begin
            is_if = ($urandom % 3) == 0;
            wr    = !is_if && ($urandom % 2);
            case ($urandom % 3)
                0:       len = 2'd0;
                1:       len = 2'd1;
                default: len = 2'd3;
            endcase
            if (is_if) len = 2'd3;
            n = int'(len) + 1;
            if (($urandom % 4) == 0) begin
                a = 32'hFFFF_FFFC + 32'($urandom % 4);
                flo = -1; fhi = -1;
            end else begin
                a = 32'h0F00 + 32'($urandom % 16);
                flo = int'($urandom_range(0, 3));
                fhi = flo + int'($urandom_range(0, 4));
            end
            d  = $urandom;
            pc = -1;
            if ($urandom % 2) pc = wr ? int'($urandom_range(1, n)) : int'($urandom_range(2, n + 1));
            if (wr) exp_c = n + 1 + ((pc >= 0) ? 1 : 0);
            else    exp_c = n + 2 + ((pc >= 0) ? 2 : 0);
            if (!wr) ld = gold_word(a, n);
            do_req(is_if, wr, len, a, d, pc, -1, flo, fhi, dc, id, nw);
            check_eq("rnd_done_cycle", dc, exp_c);
            if (wr) begin
                check_eq("rnd_nwr", nw, n);
                gold_store(a, n, d);
            end else begin
                check_eq("rnd_rdata", id, ld);
                check_eq("rnd_rd_nwr", nw, 0);
            end
        end

        // After an LSB grant, a tie goes to IF
        do_req(0, 0, 2'd0, 32'h2000, 32'h0, -1, -1, -1, -1, dc, d, nw);
        check_eq("lsb_only_data", d, 32'h0000008F);
        do_pair(32'h100, 32'h2000, ic, lc, id, ld);
        check_eq("tie2_if_cycle", ic, 6);
        check_eq("tie2_lsb_cycle", lc, 9);
        check_eq("tie2_lsb_data", ld, 32'h0000008F);

        repeat (3) @(posedge clk_in);
        check_eq("both_done_count", both_done, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: summary not reached");
        $fatal(1);
    end

endmodule
